// File: rtl/uart_block_sender.sv
// uart_block_sender: streams an optional header byte followed by a captured
// 128-bit block, MSB byte first, into a byte-wide UART transmit port using a
// strobe / wait-for-take / wait-for-idle handshake per byte.
module uart_block_sender #(
  parameter bit         HEADER_EN = 1'b1,
  parameter logic [7:0] HEADER    = 8'h41
) (
  input  logic         CLK,
  input  logic         RST,
  input  logic         START,
  input  logic [127:0] BLOCK_IN,
  input  logic         TX_IDLE,
  output logic [7:0]   TX_DATA,
  output logic         TX_ENABLE,
  output logic         BUSY,
  output logic         DONE
);

  typedef enum logic [1:0] {
    ST_IDLE      = 2'd0,
    ST_SEND      = 2'd1,
    ST_WAIT_ACK  = 2'd2,
    ST_WAIT_IDLE = 2'd3
  } state_t;

  // Index of the final byte: header occupies index 0 when enabled.
  localparam logic [4:0] LAST_IDX = HEADER_EN ? 5'd16 : 5'd15;

  state_t         state_q;
  logic [4:0]     cnt_q;
  logic [4:0]     cnt_d;
  logic [127:0]   shift_q;
  logic [127:0]   shift_d;
  logic [7:0]     tx_data_q;
  logic           tx_enable_q;
  logic           busy_q;
  logic           done_q;
  logic           hdr_slot_s;
  logic [7:0]     cur_byte_s;
  logic           last_s;

  // Select the byte for the current slot: header at index 0 (if enabled), else the top of the shift register.
  always_comb begin
    if (HEADER_EN && (cnt_q == 5'd0)) begin
      hdr_slot_s = 1'b1;
      cur_byte_s = HEADER;
    end else begin
      hdr_slot_s = 1'b0;
      cur_byte_s = shift_q[127:120];
    end
  end

  // Next counter / shift values and last-byte detection.
  always_comb begin
    cnt_d   = cnt_q + 5'd1;
    shift_d = {shift_q[119:0], 8'h00};
    last_s  = (cnt_q == LAST_IDX);
  end

  // Transfer FSM with all outputs registered; TX_ENABLE and DONE default low so they only pulse.
  always_ff @(posedge CLK) begin
    if (RST) begin
      state_q     <= ST_IDLE;
      cnt_q       <= 5'd0;
      shift_q     <= 128'd0;
      tx_data_q   <= 8'h00;
      tx_enable_q <= 1'b0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
    end else begin
      tx_enable_q <= 1'b0;
      done_q      <= 1'b0;
      case (state_q)
        ST_IDLE: begin
          if (START) begin
            shift_q <= BLOCK_IN;
            cnt_q   <= 5'd0;
            busy_q  <= 1'b1;
            state_q <= ST_SEND;
          end
        end
        ST_SEND: begin
          if (TX_IDLE) begin
            tx_data_q   <= cur_byte_s;
            tx_enable_q <= 1'b1;
            state_q     <= ST_WAIT_ACK;
          end
        end
        ST_WAIT_ACK: begin
          // The uart dropping its idle flag means it has taken the byte.
          if (!TX_IDLE) begin
            state_q <= ST_WAIT_IDLE;
          end
        end
        ST_WAIT_IDLE: begin
          if (TX_IDLE) begin
            if (last_s) begin
              busy_q  <= 1'b0;
              done_q  <= 1'b1;
              state_q <= ST_IDLE;
            end else begin
              cnt_q <= cnt_d;
              // The header byte does not consume block data.
              if (!hdr_slot_s) begin
                shift_q <= shift_d;
              end
              state_q <= ST_SEND;
            end
          end
        end
        default: begin
          busy_q  <= 1'b0;
          state_q <= ST_IDLE;
        end
      endcase
    end
  end

  assign TX_DATA   = tx_data_q;
  assign TX_ENABLE = tx_enable_q;
  assign BUSY      = busy_q;
  assign DONE      = done_q;

endmodule

// File: tb/tb_uart_block_sender.sv
// Scoreboard bench: instance 0 sends with header, instance 1 without.
// A behavioural uart (10-cycle byte time) answers each strobe; a monitor
// compares every strobed byte against the queue of expected bytes.
module tb_uart_block_sender;

  localparam logic [127:0] BLK  = 128'h2b7e151628aed2a6abf7158809cf4f3c;
  localparam logic [127:0] BLK2 = 128'h000102030405060708090a0b0c0d0e0f;

  logic         clk = 1'b0;
  logic         rst_s[2];
  logic         start_s[2];
  logic [127:0] blk_s[2];
  logic         tx_idle_s[2];
  logic [7:0]   tx_data_s[2];
  logic         tx_en_s[2];
  logic         busy_s[2];
  logic         done_s[2];

  logic         mrst = 1'b1;
  logic         u_idle[2];
  int           u_cnt[2];
  logic         stall_s[2];

  logic [7:0]   exp0[$];
  logic [7:0]   exp1[$];
  logic [7:0]   log0[$];
  logic [7:0]   log1[$];
  int           strobes[2];
  int           dones[2];
  logic         prev_en[2];
  int           tests = 0;
  int           errors = 0;

  always #5 clk = ~clk;

  uart_block_sender #(.HEADER_EN(1'b1), .HEADER(8'h41)) dut_h (
    .CLK(clk), .RST(rst_s[0]), .START(start_s[0]), .BLOCK_IN(blk_s[0]),
    .TX_IDLE(tx_idle_s[0]), .TX_DATA(tx_data_s[0]), .TX_ENABLE(tx_en_s[0]),
    .BUSY(busy_s[0]), .DONE(done_s[0])
  );

  uart_block_sender #(.HEADER_EN(1'b0), .HEADER(8'h41)) dut_n (
    .CLK(clk), .RST(rst_s[1]), .START(start_s[1]), .BLOCK_IN(blk_s[1]),
    .TX_IDLE(tx_idle_s[1]), .TX_DATA(tx_data_s[1]), .TX_ENABLE(tx_en_s[1]),
    .BUSY(busy_s[1]), .DONE(done_s[1])
  );

  assign tx_idle_s[0] = u_idle[0] & ~stall_s[0];
  assign tx_idle_s[1] = u_idle[1] & ~stall_s[1];

  // Behavioural uart: a strobe while idle makes it busy for 10 cycles.
  always @(posedge clk) begin
    for (int i = 0; i < 2; i++) begin
      if (mrst) begin
        u_idle[i] <= 1'b1;
        u_cnt[i]  <= 0;
      end else if (u_cnt[i] > 0) begin
        u_cnt[i] <= u_cnt[i] - 1;
        if (u_cnt[i] == 1) u_idle[i] <= 1'b1;
      end else if (tx_en_s[i] && u_idle[i]) begin
        u_idle[i] <= 1'b0;
        u_cnt[i]  <= 10;
      end
    end
  end

  task automatic chk(input string name, input logic [127:0] got, input logic [127:0] expv);
    tests++;
    if (got !== expv) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, got, expv, $time);
    end
  endtask

  task automatic push_exp(input int i, input logic [127:0] blk);
    if (i == 0) exp0.push_back(8'h41);
    for (int k = 15; k >= 0; k--) begin
      if (i == 0) exp0.push_back(blk[k*8 +: 8]);
      else        exp1.push_back(blk[k*8 +: 8]);
    end
  endtask

  // Monitor: pops the scoreboard on every strobe, checks strobe spacing and DONE/BUSY.
  task automatic monitor();
    logic [7:0] e;
    logic       miss;
    forever begin
      @(negedge clk);
      for (int i = 0; i < 2; i++) begin
        if (tx_en_s[i]) begin
          miss = 1'b0;
          e    = 8'h00;
          if (i == 0) begin
            if (exp0.size() == 0) miss = 1'b1; else e = exp0.pop_front();
            log0.push_back(tx_data_s[i]);
          end else begin
            if (exp1.size() == 0) miss = 1'b1; else e = exp1.pop_front();
            log1.push_back(tx_data_s[i]);
          end
          tests++;
          if (miss) begin
            errors++;
            $display("FAIL unexpected_strobe inst%0d: got %0h expected none", i, tx_data_s[i]);
          end else if (tx_data_s[i] !== e) begin
            errors++;
            $display("FAIL byte inst%0d #%0d: got %0h expected %0h", i, strobes[i], tx_data_s[i], e);
          end
          tests++;
          if (prev_en[i]) begin
            errors++;
            $display("FAIL double_strobe inst%0d: got two consecutive strobes expected one", i);
          end
          strobes[i]++;
        end
        if (done_s[i]) begin
          dones[i]++;
          tests++;
          if (busy_s[i] !== 1'b0) begin
            errors++;
            $display("FAIL done_busy inst%0d: got BUSY=%b expected 0", i, busy_s[i]);
          end
        end
        prev_en[i] = tx_en_s[i];
      end
    end
  endtask

  task automatic go(input int i, input logic [127:0] blk);
    @(posedge clk); #1;
    start_s[i] = 1'b1;
    blk_s[i]   = blk;
    push_exp(i, blk);
    @(posedge clk); #1;
    start_s[i] = 1'b0;
    chk("busy_after_start", busy_s[i], 1);
  endtask

  task automatic wait_dones(input int i, input int n, input int budget);
    int k = 0;
    while (dones[i] < n && k < budget) begin
      @(posedge clk);
      k++;
    end
    chk("done_within_budget", (dones[i] >= n), 1);
  endtask

  initial begin
    int s0, d0;
    for (int i = 0; i < 2; i++) begin
      rst_s[i] = 1'b1; start_s[i] = 1'b0; blk_s[i] = 128'd0; stall_s[i] = 1'b0;
      strobes[i] = 0; dones[i] = 0; prev_en[i] = 1'b0;
    end
    fork
      monitor();
    join_none
    repeat (3) @(posedge clk);
    #1;
    mrst = 1'b0;
    for (int i = 0; i < 2; i++) begin
      chk("reset_busy", busy_s[i], 0);
      chk("reset_txen", tx_en_s[i], 0);
      chk("reset_txdata", tx_data_s[i], 8'h00);
      chk("reset_done", done_s[i], 0);
      rst_s[i] = 1'b0;
    end

    // Header transfer
    log0.delete();
    go(0, BLK);
    wait_dones(0, 1, 600);
    chk("hdr_strobes", strobes[0], 17);
    chk("hdr_first", log0[0], 8'h41);
    chk("hdr_second", log0[1], 8'h2b);
    chk("hdr_third", log0[2], 8'h7e);
    chk("hdr_last", log0[16], 8'h3c);
    chk("hdr_queue_empty", exp0.size(), 0);

    // No header
    log1.delete();
    go(1, BLK);
    wait_dones(1, 1, 600);
    chk("nohdr_strobes", strobes[1], 16);
    chk("nohdr_first", log1[0], 8'h2b);
    chk("nohdr_last", log1[15], 8'h3c);

    // Stalled uart
    stall_s[0] = 1'b1;
    s0 = strobes[0];
    go(0, BLK);
    repeat (50) @(posedge clk);
    #1;
    chk("stall_no_strobe", strobes[0] - s0, 0);
    chk("stall_busy", busy_s[0], 1);
    stall_s[0] = 1'b0;
    @(posedge clk); #1;
    chk("stall_release_strobe", tx_en_s[0], 1);
    chk("stall_release_byte", tx_data_s[0], 8'h41);
    wait_dones(0, 2, 600);
    chk("stall_strobes", strobes[0] - s0, 17);

    // START while busy and BLOCK_IN change after capture
    d0 = dones[0];
    go(0, BLK);
    repeat (40) @(posedge clk);
    #1;
    start_s[0] = 1'b1;
    blk_s[0]   = '1;
    @(posedge clk); #1;
    start_s[0] = 1'b0;
    wait_dones(0, d0 + 1, 600);
    repeat (40) @(posedge clk);
    #1;
    chk("busy_start_one_done", dones[0] - d0, 1);
    chk("busy_start_idle", busy_s[0], 0);
    chk("busy_start_queue_empty", exp0.size(), 0);

    // Reset mid-transfer
    d0 = dones[0];
    s0 = strobes[0];
    go(0, BLK);
    begin
      int k = 0;
      while (strobes[0] - s0 < 5 && k < 300) begin
        @(posedge clk);
        k++;
      end
    end
    #1;
    chk("reset_mid_reached", (strobes[0] - s0 >= 5), 1);
    rst_s[0] = 1'b1;
    @(posedge clk); #1;
    rst_s[0] = 1'b0;
    chk("rstmid_busy", busy_s[0], 0);
    chk("rstmid_txen", tx_en_s[0], 0);
    chk("rstmid_txdata", tx_data_s[0], 8'h00);
    chk("rstmid_done", done_s[0], 0);
    exp0.delete();
    s0 = strobes[0];
    repeat (40) @(posedge clk);
    #1;
    chk("rstmid_no_done", dones[0] - d0, 0);
    chk("rstmid_no_strobe", strobes[0] - s0, 0);
    log0.delete();
    go(0, BLK);
    wait_dones(0, d0 + 1, 600);
    chk("rstmid_restart_strobes", strobes[0] - s0, 17);
    chk("rstmid_restart_first", log0[0], 8'h41);

    // Back-to-back
    d0 = dones[0];
    s0 = strobes[0];
    go(0, BLK);
    begin
      int k = 0;
      while (done_s[0] !== 1'b1 && k < 600) begin
        @(negedge clk);
        k++;
      end
    end
    chk("b2b_done_seen", done_s[0], 1);
    start_s[0] = 1'b1;
    blk_s[0]   = BLK2;
    push_exp(0, BLK2);
    @(posedge clk); #1;
    start_s[0] = 1'b0;
    chk("b2b_busy", busy_s[0], 1);
    wait_dones(0, d0 + 2, 600);
    chk("b2b_strobes", strobes[0] - s0, 34);
    chk("b2b_dones", dones[0] - d0, 2);
    chk("b2b_queue_empty", exp0.size(), 0);

    repeat (5) @(posedge clk);
    $display("[TB] %0d tests run, %0d failed", tests, errors);
    $finish;
  end

endmodule

// File: doc/uart_block_sender.md
# uart_block_sender

Transmit-side sequencer that streams a 128-bit block (cipher key, state or result) to the PC as raw bytes over the UART byte transmit interface, optionally preceded by one header byte. It sits between the command logic in the top level and the `uart` instance's transmit port (`txdatain` / `txrdyin` / `txrdyout`). It is the send-path counterpart to the byte-receive command handling: one byte in triggers a multi-byte response out.

## Interface
- `HEADER_EN`, default 1: 1 sends `HEADER` before the block; 0 sends the block only.
- `HEADER`, default 8'h41 ("A"): header byte value.
- `CLK`  in  1  — system clock; all logic on its rising edge.
- `RST`  in  1  — reset; synchronous, active-high.
- `START`  in  1  — request to send; sampled only in IDLE.
- `BLOCK_IN`  in  128  — data to send; captured on the accepted START cycle.
- `TX_IDLE`  in  1  — from uart `txrdyout`; 1 = transmitter can accept a byte.
- `TX_DATA`  out  8  — to uart `txdatain`.
- `TX_ENABLE`  out  1  — to uart `txrdyin`; one-cycle load strobe.
- `BUSY`  out  1  — 1 while a transfer is in progress.
- `DONE`  out  1  — one-cycle pulse after the last byte has finished.

## Operation
- All outputs are registered. Reset values: `TX_DATA` = 8'h00, `TX_ENABLE` = 0, `BUSY` = 0, `DONE` = 0, state IDLE, byte counter 0, shift register 0.
- States:
  - **IDLE**: on `START`=1, capture `BLOCK_IN` into a 128-bit shift register, set the counter to 0 and go to SEND.
  - **SEND**: wait for `TX_IDLE`=1. Then drive `TX_DATA` with the current byte, pulse `TX_ENABLE` and go to WAIT_ACK.
  - **WAIT_ACK**: wait for `TX_IDLE`=0, meaning the uart has taken the byte. Then go to WAIT_IDLE.
  - **WAIT_IDLE**: wait for `TX_IDLE`=1, meaning the byte has been shifted out. If this was the last byte, go to IDLE and pulse `DONE`. Otherwise increment the counter, shift the register left by 8 bits (when a block byte was sent) and go to SEND.
- Byte order:
  - Header first when `HEADER_EN`=1.
  - Then `BLOCK_IN[127:120]`, `[119:112]`, …, `[7:0]` (MSB first).
  - Total bytes: 17 with header, 16 without. The counter is 5 bits; the last index is 16 or 15.
- `BUSY` = (state ≠ IDLE), registered.
- `START` outside IDLE is ignored. It is neither queued nor able to restart the transfer.
- Changes on `BLOCK_IN` after capture do not affect the transfer in progress.
- `TX_ENABLE` is never high for two consecutive cycles. At most one strobe is issued per byte.
- `TX_IDLE` held low indefinitely stalls the block in SEND or WAIT_IDLE. There is no timeout.
- `RST` mid-transfer: return to IDLE on the next edge with all outputs at their reset values. No further strobes are issued, and no `DONE` is pulsed for the aborted transfer.

## Timing
- START accepted at edge t:
  - `BUSY`=1 from t+1.
  - With `TX_IDLE`=1 at t+1, the first `TX_ENABLE` pulse and valid `TX_DATA` appear at t+2.
- `TX_DATA` holds its value from the strobe cycle until the next strobe; it is not cleared between bytes.
- The next byte is strobed ≥1 cycle after `TX_IDLE` returns high (WAIT_IDLE → SEND → strobe).
- `DONE` is high in the first cycle back in IDLE, coinciding with `BUSY`=0.
- A `START` in that same cycle is accepted, giving back-to-back transfers.
- Minimum transfer length, if the uart drops `TX_IDLE` immediately: 17 header bytes × 4 cycles + 1.

## Test plan
- **Header transfer:** `HEADER_EN`=1, `BLOCK_IN`=128'h2b7e151628aed2a6abf7158809cf4f3c, uart model with 10-cycle byte time → exactly 17 strobes with bytes 0x41, 0x2b, 0x7e, 0x15, …, 0x4f, 0x3c; then one `DONE` pulse; `BUSY` falls with `DONE`.
- **No header:** `HEADER_EN`=0, same block → 16 strobes, first byte 0x2b, last 0x3c.
- **Stalled uart:** `TX_IDLE` held 0 for 50 cycles after START → no `TX_ENABLE`, `BUSY`=1. After release, first strobe 1 cycle later.
- **Busy START and capture:** START pulsed mid-transfer while `BLOCK_IN` changes to all-ones → ignored; output bytes still match the captured block; exactly one `DONE`.
- **Reset mid-transfer:** `RST` after byte 5 → next cycle `BUSY`=0, `TX_ENABLE`=0, `TX_DATA`=0x00; no `DONE`. A new START then sends the full sequence from the header.
- **Back-to-back:** START asserted in the `DONE` cycle → second transfer begins; 34 total strobes; two `DONE` pulses.
